alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec.sv | 176 +++++++++++++++++
 tb/tb_alu_exec.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// Single-issue ALU execution stage: one-cycle logic/arithmetic/compare ops and
// bit-serial shifts (one bit per cycle) behind a valid/ready handshake.
module alu_exec #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            operation,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  typedef enum logic [3:0] {
    OP_AND  = 4'b0000,
    OP_OR   = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SLL  = 4'b0011,
    OP_SRL  = 4'b0100,
    OP_SUB  = 4'b0101,
    OP_SRA  = 4'b0110,
    OP_SLT  = 4'b0111,
    OP_BEQ  = 4'b1000,
    OP_BNE  = 4'b1001,
    OP_BLT  = 4'b1010,
    OP_BGE  = 4'b1011,
    OP_XOR  = 4'b1100,
    OP_LUI  = 4'b1101,
    OP_RES0 = 4'b1110,
    OP_RES1 = 4'b1111
  } alu_op_e;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e                  state_q, state_d;
  logic [SHAMT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
  alu_op_e                 shop_q, shop_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    zero_q, zero_d;
  logic                    out_valid_q, out_valid_d;

  logic [DATA_WIDTH-1:0]   alu_res;
  logic [DATA_WIDTH-1:0]   shifted;
  logic [SHAMT_W-1:0]      shamt;
  logic                    is_shift;
  alu_op_e                 op_in;

  function automatic logic [DATA_WIDTH-1:0] flag(input logic cond);
    return {{(DATA_WIDTH-1){1'b0}}, cond};
  endfunction

  // Shift ops only reach this path with a zero shift amount, so they pass src_a.
  function automatic logic [DATA_WIDTH-1:0] alu_f(input alu_op_e op,
                                                  input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] r;
    case (op)
      OP_AND:                 r = a & b;
      OP_OR:                  r = a | b;
      OP_ADD:                 r = a + b;
      OP_SUB:                 r = a - b;
      OP_SLL, OP_SRL, OP_SRA: r = a;
      OP_SLT, OP_BLT:         r = flag($signed(a) < $signed(b));
      OP_BEQ:                 r = flag(a == b);
      OP_BNE:                 r = flag(a != b);
      OP_BGE:                 r = flag($signed(a) >= $signed(b));
      OP_XOR:                 r = a ^ b;
      OP_LUI:                 r = b;
      default:                r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift1(input alu_op_e op,
                                                   input logic [DATA_WIDTH-1:0] v);
    logic [DATA_WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = {v[DATA_WIDTH-2:0], 1'b0};
      OP_SRL:  r = {1'b0, v[DATA_WIDTH-1:1]};
      default: r = {v[DATA_WIDTH-1], v[DATA_WIDTH-1:1]};
    endcase
    return r;
  endfunction

  always_comb begin
    op_in       = alu_op_e'(operation);
    shamt       = src_b[SHAMT_W-1:0];
    is_shift    = (op_in == OP_SLL) || (op_in == OP_SRL) || (op_in == OP_SRA);
    alu_res     = alu_f(op_in, src_a, src_b);
    shifted     = shift1(shop_q, shreg_q);

    state_d     = state_q;
    count_d     = count_q;
    shreg_d     = shreg_q;
    shop_d      = shop_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_shift && (shamt != '0)) begin
            state_d = SHIFT;
            count_d = shamt;
            shreg_d = src_a;
            shop_d  = op_in;
          end else begin
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        shreg_d = shifted;
        count_d = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          state_d     = IDLE;
          result_d    = shifted;
          zero_d      = (shifted == '0);
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides both acceptance and shift completion; outputs keep old values.
    if (flush) begin
      state_d     = IDLE;
      count_d     = '0;
      shreg_d     = shreg_q;
      shop_d      = shop_q;
      result_d    = result_q;
      zero_d      = zero_q;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shreg_q     <= '0;
      shop_q      <= OP_AND;
      result_q    <= '0;
      zero_q      <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shreg_q     <= shreg_d;
      shop_q      <= shop_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: vector table through a result scoreboard,
// plus directed shift/flush/reset sequences.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, zero;
  logic [3:0]  operation;
  logic [31:0] src_a, src_b, result;

  always #5 clk = ~clk;

  alu_exec #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .operation (operation),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .result    (result),
    .zero      (zero)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 22;
  vec_t        vecs [NV];
  logic [31:0] sb [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_exp;
  int          busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    operation = op;
    src_a     = a;
    src_b     = b;
    in_valid  = 1'b1;
  endtask

  // Scoreboard consumer: every out_valid pulse must match the oldest pending result.
  always @(posedge clk) begin
    logic [31:0] exp_m;
    #1;
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got out_valid=1 result=%h required no pulse", result);
      end else begin
        exp_m = sb.pop_front();
        check("sb_result", result, exp_m);
        check("sb_zero", {31'b0, zero}, {31'b0, (exp_m == 32'h0)});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach end of test");
    $fatal(1, "timeout");
  end

  initial begin
    vecs = '{
      '{4'h0, 32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234},
      '{4'h1, 32'h000000F0, 32'h0000000F, 32'h000000FF},
      '{4'h2, 32'h00000005, 32'h00000007, 32'h0000000C},
      '{4'h2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000},
      '{4'h5, 32'h00000010, 32'h00000010, 32'h00000000},
      '{4'h5, 32'h00000000, 32'h00000001, 32'hFFFFFFFF},
      '{4'h7, 32'hFFFFFFFF, 32'h00000001, 32'h00000001},
      '{4'hB, 32'hFFFFFFFF, 32'h00000001, 32'h00000000},
      '{4'h7, 32'h00000001, 32'hFFFFFFFF, 32'h00000000},
      '{4'h8, 32'h00000003, 32'h00000003, 32'h00000001},
      '{4'h9, 32'h00000003, 32'h00000003, 32'h00000000},
      '{4'h9, 32'h00000003, 32'h00000004, 32'h00000001},
      '{4'hA, 32'h80000000, 32'h00000000, 32'h00000001},
      '{4'hB, 32'h00000005, 32'h00000005, 32'h00000001},
      '{4'hC, 32'h000000FF, 32'h0000000F, 32'h000000F0},
      '{4'h1, 32'h000000F0, 32'h0000000F, 32'h000000FF},
      '{4'hD, 32'h00000123, 32'hABCD0000, 32'hABCD0000},
      '{4'hE, 32'h00001234, 32'h00005678, 32'h00000000},
      '{4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
      '{4'h3, 32'hDEADBEEF, 32'h00000020, 32'hDEADBEEF},
      '{4'h6, 32'h80000001, 32'h00000040, 32'h80000001},
      '{4'h4, 32'h12345678, 32'hFFFFFFE0, 32'h12345678}
    };

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
    operation = 4'h0; src_a = '0; src_b = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_zero", {31'b0, zero}, 32'h1);

    // Back-to-back single-cycle ops from the table.
    for (int i = 0; i < NV; i++) begin
      check("tbl_in_ready", {31'b0, in_ready}, 32'h1);
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      sb.push_back(vecs[i].exp);
      last_exp = vecs[i].exp;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("tbl_drain", 32'(sb.size()), 32'h0);

    // ADD latency 1 and result hold.
    drive(4'h2, 32'd5, 32'd7);
    sb.push_back(32'd12); last_exp = 32'd12;
    @(negedge clk);
    in_valid = 1'b0;
    check("add_out_valid", {31'b0, out_valid}, 32'h1);
    check("add_result", result, 32'd12);
    check("add_zero", {31'b0, zero}, 32'h0);
    @(negedge clk);
    check("add_pulse_end", {31'b0, out_valid}, 32'h0);
    check("add_hold", result, 32'd12);

    // SRA by 4 with garbage requests presented while busy.
    drive(4'h6, 32'h80000000, 32'd4);
    sb.push_back(32'hF8000000); last_exp = 32'hF8000000;
    @(negedge clk);
    busy = 0;
    for (int c = 0; c < 50; c++) begin
      if (in_ready) break;
      busy++;
      drive(4'h2, $urandom, $urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("sra_busy_cycles", busy, 32'd4);
    check("sra_out_valid", {31'b0, out_valid}, 32'h1);
    check("sra_result", result, 32'hF8000000);
    @(negedge clk);
    check("sra_pulse_end", {31'b0, out_valid}, 32'h0);

    // SLL by 31 flushed in its third shift cycle.
    drive(4'h3, 32'h1, 32'd31);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_in_ready", {31'b0, in_ready}, 32'h1);
    check("flush_out_valid", {31'b0, out_valid}, 32'h0);
    check("flush_result", result, last_exp);
    repeat (3) @(negedge clk);
    check("flush_no_late", {31'b0, out_valid}, 32'h0);
    drive(4'h2, 32'd1, 32'd1);
    sb.push_back(32'd2); last_exp = 32'd2;
    @(negedge clk);
    in_valid = 1'b0;
    check("post_flush_add_valid", {31'b0, out_valid}, 32'h1);
    check("post_flush_add", result, 32'd2);
    @(negedge clk);

    // Flush on the completion edge of a 2-bit SRL.
    drive(4'h4, 32'h100, 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_cmpl_valid", {31'b0, out_valid}, 32'h0);
    check("flush_cmpl_result", result, last_exp);
    check("flush_cmpl_ready", {31'b0, in_ready}, 32'h1);

    // Flush blocks acceptance in IDLE.
    drive(4'h2, 32'd2, 32'd3);
    flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b0;
    check("flush_idle_valid", {31'b0, out_valid}, 32'h0);
    check("flush_idle_result", result, last_exp);
    @(negedge clk);

    // Reset during SRL by 10, with a competing request in the reset cycle.
    drive(4'h4, 32'hFFFF0000, 32'd10);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    drive(4'h2, 32'd5, 32'd7);
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    last_exp = 32'h0;
    check("rst_mid_result", result, 32'h0);
    check("rst_mid_zero", {31'b0, zero}, 32'h1);
    check("rst_mid_valid", {31'b0, out_valid}, 32'h0);
    check("rst_mid_ready", {31'b0, in_ready}, 32'h1);
    repeat (12) @(negedge clk);
    check("rst_mid_no_late", {31'b0, out_valid}, 32'h0);
    check("rst_mid_hold", result, 32'h0);

    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
